// File: rtl/pool_pkg.sv
// Shared types and widths for the pooling / requantisation stage.
//   pool_state_t : controller states
//   ACC_W        : width of the convolution accumulator words
//   OUT_W        : width of the requantised output words
//   SAT_MAX      : largest positive output value
package pool_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } pool_state_t;

  localparam int ACC_W   = 32;
  localparam int OUT_W   = 8;
  localparam int SAT_MAX = 127;

endpackage

// File: rtl/pool_requant_if.sv
// Map-level handshake between the convolution controller side and the
// pooling stage.
//   start    : begin a pass (master -> slave)
//   inputs   : INSIZE x INSIZE signed accumulator map (master -> slave)
//   bias     : per-map bias (master -> slave)
//   outputs  : INSIZE/2 x INSIZE/2 signed 8-bit map (slave -> master)
//   all_done : pass complete, outputs valid (slave -> master)
interface pool_requant_if #(
  parameter int INSIZE = 28
);
  import pool_pkg::*;

  localparam int OUT = INSIZE / 2;

  logic                    start;
  logic signed [ACC_W-1:0] inputs  [INSIZE][INSIZE];
  logic signed [ACC_W-1:0] bias;
  logic signed [OUT_W-1:0] outputs [OUT][OUT];
  logic                    all_done;

  modport master (
    output start, inputs, bias,
    input  outputs, all_done
  );

  modport slave (
    input  start, inputs, bias,
    output outputs, all_done
  );

endinterface

// File: rtl/requant_relu.sv
// Combinational requantiser: adds bias and a half-LSB rounding constant,
// arithmetic-shifts right by SHIFT, then clamps to [0, 2^(OUT_W-1)-1].
//   acc  : signed accumulator value
//   bias : signed bias
//   q    : requantised, ReLU'd, saturated result
module requant_relu #(
  parameter int SHIFT = 8,
  parameter int ACC_W = 32,
  parameter int OUT_W = 8
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic signed [ACC_W-1:0] bias,
  output logic signed [OUT_W-1:0] q
);

  // Two guard bits: the sum of two ACC_W values plus the rounding constant
  // cannot overflow.
  localparam int SW = ACC_W + 2;
  localparam logic signed [SW-1:0] RND = {{(SW-1){1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [SW-1:0] SAT = SW'((1 << (OUT_W - 1)) - 1);

  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] shr;

  always_comb begin
    sum = {{2{acc[ACC_W-1]}}, acc} + {{2{bias[ACC_W-1]}}, bias} + RND;
    shr = sum >>> SHIFT;
    if (shr[SW-1]) begin
      q = '0;
    end else if (shr > SAT) begin
      q = SAT[OUT_W-1:0];
    end else begin
      q = shr[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/pool_requant.sv
// 2x2 stride-2 max-pool followed by bias / rounding shift / ReLU / saturation.
// Walks the output map in raster order, spending four cycles gathering the
// window maximum and one cycle writing the requantised pixel.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : pool_requant_if slave (start, inputs, bias, outputs, all_done)
//
// state | meaning
// IDLE  | waiting for the first start after reset
// LOAD  | k=0..3 walks the 2x2 window, keeping the signed maximum
// WRITE | requantise the window maximum into outputs[y][x]
// DONE  | map complete, all_done high; start launches another pass
module pool_requant
  import pool_pkg::*;
#(
  parameter int INSIZE = 28,
  parameter int SHIFT  = 8
) (
  input logic           clk,
  input logic           rst_n,
  pool_requant_if.slave bus
);

  localparam int OUT = INSIZE / 2;
  localparam int XW  = (OUT > 1) ? $clog2(OUT) : 1;

  if (INSIZE % 2 != 0) begin : g_bad_insize
    $error("pool_requant: INSIZE must be even");
  end
  if (SHIFT < 1 || SHIFT > 31) begin : g_bad_shift
    $error("pool_requant: SHIFT must be in 1..31");
  end

  pool_state_t             state, state_nxt;
  logic [XW-1:0]           x, y;
  logic [1:0]              k;
  logic signed [ACC_W-1:0] max_reg;
  logic signed [ACC_W-1:0] win_val;
  logic signed [OUT_W-1:0] q;
  logic signed [OUT_W-1:0] out_q [OUT][OUT];
  logic                    last_x, last_y;

  assign last_x = (x == XW'(OUT - 1));
  assign last_y = (y == XW'(OUT - 1));

  // Window element k: row 2y+k[1], column 2x+k[0].
  assign win_val = bus.inputs[{y, k[1]}][{x, k[0]}];

  requant_relu #(
    .SHIFT (SHIFT),
    .ACC_W (ACC_W),
    .OUT_W (OUT_W)
  ) u_requant (
    .acc  (max_reg),
    .bias (bus.bias),
    .q    (q)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = LOAD;
      LOAD:    if (k == 2'd3) state_nxt = WRITE;
      WRITE:   state_nxt = (last_x && last_y) ? DONE : LOAD;
      DONE:    if (bus.start) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      x       <= '0;
      y       <= '0;
      k       <= '0;
      max_reg <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            x <= '0;
            y <= '0;
            k <= '0;
          end
        end
        LOAD: begin
          k <= k + 2'd1;
          if (k == 2'd0 || win_val > max_reg) begin
            max_reg <= win_val;
          end
        end
        WRITE: begin
          k <= '0;
          if (!(last_x && last_y)) begin
            if (last_x) begin
              x <= '0;
              y <= y + XW'(1);
            end else begin
              x <= x + XW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OUT; i++) begin
        for (int j = 0; j < OUT; j++) begin
          out_q[i][j] <= '0;
        end
      end
    end else if (state == WRITE) begin
      out_q[y][x] <= q;
    end
  end

  assign bus.outputs  = out_q;
  assign bus.all_done = (state == DONE);

endmodule
